// File: rtl/bp_cache_req_arbiter.sv
// bp_cache_req_arbiter
//
// Merges the request streams of several cache engines onto one downstream
// request channel. Grants are issued round-robin among ports that have a
// request and a free credit. A grant, once presented, is held until the
// downstream side accepts it. A locked acceptance keeps ownership with the
// same port until an unlocked acceptance releases it. Per-port credit
// counters track outstanding requests and are returned by "last" return
// beats. Return strobes are routed back to the owning port.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   req_i / req_v_i           per-port request packets and valids
//   req_yumi_o                per-port acceptance (granted port only)
//   req_metadata_i / _v_i     per-port metadata, muxed the cycle after accept
//   credits_full_o / _empty_o per-port credit status
//   critical_o / last_o       return strobes routed to the returning port
//   arb_req_*                 merged downstream request channel
//   arb_metadata_o / _v_o     merged metadata of the last accepted port
//   ret_*                     return notification from downstream
module bp_cache_req_arbiter #(
  parameter int ports_p          = 2,
  parameter int req_width_p      = 128,
  parameter int metadata_width_p = 8,
  parameter int credits_p        = 4,
  localparam int port_id_width_lp = (ports_p > 1) ? $clog2(ports_p) : 1,
  localparam int cnt_width_lp     = $clog2(credits_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [ports_p*req_width_p-1:0]        req_i,
  input  logic [ports_p-1:0]                    req_v_i,
  output logic [ports_p-1:0]                    req_yumi_o,
  input  logic [ports_p*metadata_width_p-1:0]   req_metadata_i,
  input  logic [ports_p-1:0]                    req_metadata_v_i,
  output logic [ports_p-1:0]                    credits_full_o,
  output logic [ports_p-1:0]                    credits_empty_o,
  output logic [ports_p-1:0]                    critical_o,
  output logic [ports_p-1:0]                    last_o,
  output logic [req_width_p-1:0]                arb_req_o,
  output logic                                  arb_req_v_o,
  output logic [port_id_width_lp-1:0]           arb_req_port_o,
  input  logic                                  arb_req_yumi_i,
  input  logic                                  arb_req_lock_i,
  output logic [metadata_width_p-1:0]           arb_metadata_o,
  output logic                                  arb_metadata_v_o,
  input  logic                                  ret_v_i,
  input  logic [port_id_width_lp-1:0]           ret_port_i,
  input  logic                                  ret_critical_i,
  input  logic                                  ret_last_i
);

  logic [cnt_width_lp-1:0]     r_cnt [ports_p];
  logic [port_id_width_lp-1:0] r_rr_ptr;
  logic [port_id_width_lp-1:0] r_grant_port;
  logic [port_id_width_lp-1:0] r_lock_owner;
  logic [port_id_width_lp-1:0] r_meta_owner;
  logic                        r_grant_pend;
  logic                        r_locked;
  logic                        r_meta_v;

  logic [ports_p-1:0]          w_full;
  logic [ports_p-1:0]          w_empty;
  logic [ports_p-1:0]          w_eligible;
  logic [ports_p-1:0]          w_cnt_inc;
  logic [ports_p-1:0]          w_cnt_dec;
  logic                        w_any_elig;
  logic [port_id_width_lp-1:0] w_sel_port;
  logic [port_id_width_lp-1:0] w_grant_port;
  logic                        w_grant_v;
  logic                        w_yumi;

  // Credit status comes straight from the counters, so a credit freed this
  // cycle only makes its port eligible from the next cycle on.
  always_comb begin
    w_full     = '0;
    w_empty    = '0;
    w_eligible = '0;
    w_cnt_inc  = '0;
    w_cnt_dec  = '0;
    for (int p = 0; p < ports_p; p++) begin
      w_full[p]     = (r_cnt[p] == cnt_width_lp'(credits_p));
      w_empty[p]    = (r_cnt[p] == '0);
      w_eligible[p] = req_v_i[p] & ~w_full[p]
                    & (~r_locked | (r_lock_owner == port_id_width_lp'(p)));
      w_cnt_inc[p]  = w_yumi & (w_grant_port == port_id_width_lp'(p));
      // Out-of-range return ports never match any p, so they are ignored.
      w_cnt_dec[p]  = ret_v_i & ret_last_i & (ret_port_i == port_id_width_lp'(p));
    end
  end

  // Round-robin pick: scan from rr_ptr upward with wrap, first eligible wins.
  always_comb begin
    int idx;
    idx        = 0;
    w_any_elig = 1'b0;
    w_sel_port = '0;
    for (int k = 0; k < ports_p; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= ports_p) idx = idx - ports_p;
      if (!w_any_elig && w_eligible[idx]) begin
        w_any_elig = 1'b1;
        w_sel_port = port_id_width_lp'(idx);
      end
    end
  end

  // A presented but unaccepted grant takes priority over a fresh pick so the
  // downstream side sees a stable request. Reset masks the combinational path.
  assign w_grant_v    = reset_n_i & (r_grant_pend | w_any_elig);
  assign w_grant_port = r_grant_pend ? r_grant_port : w_sel_port;
  assign w_yumi       = w_grant_v & arb_req_yumi_i;

  assign arb_req_v_o     = w_grant_v;
  assign arb_req_port_o  = w_grant_port;
  assign credits_full_o  = w_full;
  assign credits_empty_o = w_empty;

  // Output muxes for request data, metadata and routed return strobes.
  always_comb begin
    arb_req_o        = '0;
    req_yumi_o       = '0;
    arb_metadata_o   = '0;
    arb_metadata_v_o = 1'b0;
    critical_o       = '0;
    last_o           = '0;
    for (int p = 0; p < ports_p; p++) begin
      if (w_grant_port == port_id_width_lp'(p)) begin
        arb_req_o     = req_i[p*req_width_p +: req_width_p];
        req_yumi_o[p] = w_yumi;
      end
      if (r_meta_owner == port_id_width_lp'(p)) begin
        arb_metadata_o   = req_metadata_i[p*metadata_width_p +: metadata_width_p];
        arb_metadata_v_o = r_meta_v & req_metadata_v_i[p];
      end
      critical_o[p] = reset_n_i & ret_v_i & ret_critical_i
                    & (ret_port_i == port_id_width_lp'(p));
      last_o[p]     = reset_n_i & ret_v_i & ret_last_i
                    & (ret_port_i == port_id_width_lp'(p));
    end
  end

  // Arbitration state, lock ownership, metadata owner and credit counters.
  // A locked acceptance leaves rr_ptr alone; only an unlocked one advances it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rr_ptr     <= '0;
      r_grant_port <= '0;
      r_lock_owner <= '0;
      r_meta_owner <= '0;
      r_grant_pend <= 1'b0;
      r_locked     <= 1'b0;
      r_meta_v     <= 1'b0;
      for (int p = 0; p < ports_p; p++) r_cnt[p] <= '0;
    end else begin
      r_meta_v <= w_yumi;
      if (w_yumi) begin
        r_grant_pend <= 1'b0;
        r_meta_owner <= w_grant_port;
        if (arb_req_lock_i) begin
          r_locked     <= 1'b1;
          r_lock_owner <= w_grant_port;
        end else begin
          r_locked <= 1'b0;
          r_rr_ptr <= (w_grant_port == port_id_width_lp'(ports_p - 1))
                    ? '0 : w_grant_port + 1'b1;
        end
      end else if (w_grant_v) begin
        r_grant_pend <= 1'b1;
        r_grant_port <= w_grant_port;
      end
      for (int p = 0; p < ports_p; p++) begin
        if (w_cnt_inc[p] && !w_cnt_dec[p] && !w_full[p])
          r_cnt[p] <= r_cnt[p] + 1'b1;
        else if (w_cnt_dec[p] && !w_cnt_inc[p] && !w_empty[p])
          r_cnt[p] <= r_cnt[p] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// tb_bp_cache_req_arbiter
//
// Drives the arbiter with directed scenarios and then random traffic, and
// compares every output each cycle against a behavioural model of the
// arbitration, credit and metadata rules. Inputs change on the falling edge
// and outputs are sampled 1 ns later.
module tb_bp_cache_req_arbiter;

  localparam int P = 4;
  localparam int W = 16;
  localparam int M = 8;
  localparam int C = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [P*W-1:0]  req = '0;
  logic [P-1:0]    reqV = '0;
  logic [P-1:0]    reqYumi;
  logic [P*M-1:0]  md = '0;
  logic [P-1:0]    mdV = '0;
  logic [P-1:0]    credFull, credEmpty, crit, last;
  logic [W-1:0]    arbReq;
  logic            arbV;
  logic [1:0]      arbPort;
  logic            yumi = 1'b0;
  logic            lock = 1'b0;
  logic [M-1:0]    arbMd;
  logic            arbMdV;
  logic            retV = 1'b0;
  logic [1:0]      retPort = '0;
  logic            retCrit = 1'b0;
  logic            retLast = 1'b0;

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model state
  int mCnt [P];
  int mRr;
  bit mLocked;
  int mOwner;
  bit mPend;
  int mPendPort;
  bit mMetaPh;
  int mMetaOwner;
  bit eV;
  int eG;

  bp_cache_req_arbiter #(
    .ports_p(P), .req_width_p(W), .metadata_width_p(M), .credits_p(C)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_i(req), .req_v_i(reqV), .req_yumi_o(reqYumi),
    .req_metadata_i(md), .req_metadata_v_i(mdV),
    .credits_full_o(credFull), .credits_empty_o(credEmpty),
    .critical_o(crit), .last_o(last),
    .arb_req_o(arbReq), .arb_req_v_o(arbV), .arb_req_port_o(arbPort),
    .arb_req_yumi_i(yumi), .arb_req_lock_i(lock),
    .arb_metadata_o(arbMd), .arb_metadata_v_o(arbMdV),
    .ret_v_i(retV), .ret_port_i(retPort), .ret_critical_i(retCrit),
    .ret_last_i(retLast)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int p = 0; p < P; p++) mCnt[p] = 0;
    mRr = 0; mLocked = 0; mOwner = 0; mPend = 0; mPendPort = 0;
    mMetaPh = 0; mMetaOwner = 0;
  endtask

  // Work out what the arbiter must show this cycle and compare everything.
  task automatic checkOutput();
    logic [P-1:0] expY, expFull, expEmpty, expCrit, expLast;
    bit expMdV;
    if (!reset_n) resetModel();
    eV = 0; eG = 0;
    if (mPend) begin
      eV = 1; eG = mPendPort;
    end else begin
      for (int k = 0; k < P; k++) begin
        int idx;
        idx = (mRr + k) % P;
        if (!eV && reqV[idx] && mCnt[idx] != C && (!mLocked || idx == mOwner)) begin
          eV = 1; eG = idx;
        end
      end
    end
    if (!reset_n) eV = 0;
    expY = (eV && yumi) ? P'(1 << eG) : '0;
    for (int p = 0; p < P; p++) begin
      expFull[p]  = (mCnt[p] == C);
      expEmpty[p] = (mCnt[p] == 0);
    end
    expCrit = (reset_n && retV && retCrit) ? P'(1 << retPort) : '0;
    expLast = (reset_n && retV && retLast) ? P'(1 << retPort) : '0;
    expMdV  = reset_n && mMetaPh && mdV[mMetaOwner];
    cmp("arb_req_v", 64'(arbV), 64'(eV));
    if (eV) begin
      cmp("arb_req_port", 64'(arbPort), 64'(eG));
      cmp("arb_req_data", 64'(arbReq), 64'(req[eG*W +: W]));
    end
    cmp("req_yumi", 64'(reqYumi), 64'(expY));
    cmp("credits_full", 64'(credFull), 64'(expFull));
    cmp("credits_empty", 64'(credEmpty), 64'(expEmpty));
    cmp("critical", 64'(crit), 64'(expCrit));
    cmp("last", 64'(last), 64'(expLast));
    cmp("metadata_v", 64'(arbMdV), 64'(expMdV));
    if (expMdV) cmp("metadata", 64'(arbMd), 64'(md[mMetaOwner*M +: M]));
  endtask

  task automatic applyStimulus(input bit rstn, input logic [P-1:0] rv, input bit y,
                               input bit lk, input bit rtv, input logic [1:0] rp,
                               input bit rc, input bit rl, input logic [P-1:0] mv);
    @(negedge clk);
    reset_n = rstn;
    reqV    = rv;
    req     = {$urandom(), $urandom()};
    md      = $urandom();
    mdV     = mv;
    yumi    = y;
    lock    = lk;
    retV    = rtv;
    retPort = rp;
    retCrit = rc;
    retLast = rl;
    #1;
    checkOutput();
  endtask

  // Advance the model across the rising edge using the inputs held this cycle.
  task automatic endCycle();
    bit inc, dec;
    @(posedge clk);
    if (!reset_n) begin
      resetModel();
      return;
    end
    inc = eV && yumi;
    dec = retV && retLast;
    for (int p = 0; p < P; p++) begin
      int d;
      d = ((inc && eG == p) ? 1 : 0) - ((dec && retPort == p) ? 1 : 0);
      if (d > 0 && mCnt[p] < C) mCnt[p]++;
      else if (d < 0 && mCnt[p] > 0) mCnt[p]--;
    end
    if (inc) begin
      mPend = 0; mMetaPh = 1; mMetaOwner = eG;
      if (lock) begin
        mLocked = 1; mOwner = eG;
      end else begin
        mLocked = 0; mRr = (eG + 1) % P;
      end
    end else begin
      mMetaPh = 0;
      if (eV) begin
        mPend = 1; mPendPort = eG;
      end
    end
  endtask

  initial begin
    logic [P-1:0] rv;
    int rrSeq [5] = '{0, 1, 2, 3, 0};
    resetModel();

    // Reset state
    applyStimulus(0, 4'hF, 1, 0, 1, 2'd1, 1, 1, 4'hF);
    cmp("reset_v", 64'(arbV), 64'd0);
    cmp("reset_empty", 64'(credEmpty), 64'hF);
    cmp("reset_strobes", 64'({crit, last, reqYumi}), 64'd0);
    endCycle();

    // Round-robin sweep with every port requesting
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'hF, 1, 0, 0, 2'd0, 0, 0, 4'h0);
      cmp("rr_seq", 64'(arbPort), 64'(rrSeq[i]));
      endCycle();
    end

    // Lock on port 1 with simultaneous last returns keeping its count at 1
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b0111, 1, (i < 2), 1, 2'd1, 1, 1, 4'h0);
      cmp("lock_port", 64'(arbPort), 64'd1);
      cmp("lock_critical", 64'(crit), 64'b0010);
      endCycle();
    end
    applyStimulus(1, 4'b0111, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    cmp("unlock_port", 64'(arbPort), 64'd2);
    cmp("simul_empty1", 64'(credEmpty[1]), 64'd0);
    endCycle();

    // Reset drops the pending grant on port 2; next grant from port 0
    applyStimulus(0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    endCycle();
    applyStimulus(1, 4'hF, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    cmp("post_reset_port", 64'(arbPort), 64'd0);
    endCycle();

    // Credits: fill port 0, return one, regain eligibility one cycle later
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b0001, 1, 0, 0, 2'd0, 0, 0, 4'h0);
      cmp("credit_port", 64'(arbPort), 64'd0);
      endCycle();
    end
    applyStimulus(1, 4'b0001, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    cmp("full_v", 64'(arbV), 64'd0);
    cmp("full_flag", 64'(credFull[0]), 64'd1);
    endCycle();
    applyStimulus(1, 4'b0001, 1, 0, 1, 2'd0, 0, 1, 4'h0);
    cmp("free_same_cycle_v", 64'(arbV), 64'd0);
    endCycle();
    applyStimulus(1, 4'b0001, 1, 0, 0, 2'd0, 0, 0, 4'h0);
    cmp("free_next_full", 64'(credFull[0]), 64'd0);
    cmp("free_next_v", 64'(arbV), 64'd1);
    endCycle();

    // Metadata follows the port accepted the previous cycle
    applyStimulus(1, 4'b0100, 1, 0, 0, 2'd0, 0, 0, 4'h0);
    cmp("meta_grant", 64'(arbPort), 64'd2);
    endCycle();
    applyStimulus(1, 4'b0000, 0, 0, 0, 2'd0, 0, 0, 4'b0100);
    cmp("meta_v", 64'(arbMdV), 64'd1);
    endCycle();

    // Asynchronous reset while locked with three outstanding on port 1
    applyStimulus(0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'b0010, 1, (i > 0), 0, 2'd0, 0, 0, 4'h0);
      endCycle();
    end
    applyStimulus(1, 4'hF, 0, 0, 0, 2'd0, 0, 0, 4'hF);
    cmp("locked_full_v", 64'(arbV), 64'd0);
    cmp("locked_full", 64'(credFull), 64'b0010);
    #2 reset_n = 1'b0;
    #1;
    checkOutput();
    cmp("async_full", 64'(credFull), 64'd0);
    cmp("async_empty", 64'(credEmpty), 64'hF);
    cmp("async_meta_v", 64'(arbMdV), 64'd0);
    endCycle();
    applyStimulus(1, 4'hF, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    cmp("async_next_port", 64'(arbPort), 64'd0);
    endCycle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rv = P'($urandom());
      if (mPend) rv[mPendPort] = 1'b1;
      applyStimulus(($urandom_range(99) != 0), rv, $urandom_range(1),
                    ($urandom_range(3) == 0), $urandom_range(1), 2'($urandom_range(3)),
                    $urandom_range(1), $urandom_range(1), P'($urandom()));
      endCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
